// File: rtl/mux4_rr_sel_ctrl.sv
// Round-robin arbiter and select controller for a shared 4:1 mux.
// One-hot grant with a hold limit; sel drives the mux select directly.
module mux4_rr_sel_ctrl #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       sel_valid
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [3:0]       others_s;
  logic [2:0]       idle_pick_s;
  logic [2:0]       own_pick_s;

  // Returns {found, index}: first set candidate at base+1 .. base+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] cand);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (cand[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign others_s    = req & ~(4'b0001 << sel_q);
  assign idle_pick_s = rr_pick(ptr_q, req);
  assign own_pick_s  = rr_pick(sel_q, others_s);

  // Next-state and next-output decision.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_pick_s[2]) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << idle_pick_s[1:0];
          sel_d   = idle_pick_s[1:0];
          valid_d = 1'b1;
          hold_d  = HOLD_ONE;
          ptr_d   = idle_pick_s[1:0];
        end else begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        // Handover on release, or on expiry once someone else is waiting.
        if ((!req[sel_q] || (hold_q == HOLD_MAX)) && own_pick_s[2]) begin
          gnt_d   = 4'b0001 << own_pick_s[1:0];
          sel_d   = own_pick_s[1:0];
          valid_d = 1'b1;
          hold_d  = HOLD_ONE;
          ptr_d   = own_pick_s[1:0];
        end else if (!req[sel_q]) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d  = hold_q + HOLD_ONE;
        end else begin
          hold_d  = hold_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign sel_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_sel_ctrl.sv
// Scoreboard bench for mux4_rr_sel_ctrl (MAX_HOLD=2): directed scenarios then random traffic,
// checked against a behavioural owner/hold/pointer model and a bench-side 4:1 mux.
module tb_mux4_rr_sel_ctrl;

  localparam int MAXH = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       sel_valid;
  logic [3:0] mux_in;
  logic       mux_out;

  mux4_rr_sel_ctrl #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid)
  );

  assign mux_out = mux_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       dout;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // Reference model state
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 3;
  int m_sel   = 0;

  function automatic int next_from(input int b, input logic [3:0] r, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (b + k) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_owner = w;
    m_hold  = 1;
    m_ptr   = w;
    m_sel   = w;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] r);
    int w;
    if (!rst) begin
      m_owner = -1; m_hold = 0; m_ptr = 3; m_sel = 0;
    end else if (m_owner < 0) begin
      w = next_from(m_ptr, r, -1);
      if (w >= 0) give(w);
    end else if (!r[m_owner]) begin
      w = next_from(m_owner, r, m_owner);
      if (w >= 0) give(w);
      else m_owner = -1;
    end else if (m_hold >= MAXH && next_from(m_owner, r, m_owner) >= 0) begin
      give(next_from(m_owner, r, m_owner));
    end else begin
      m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
    end
  endtask

  // Apply one cycle of stimulus and queue what the DUT must show after the next edge.
  task automatic cycle(input logic rst, input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    rst_n  = rst;
    req    = r;
    mux_in = 4'($urandom);
    model_step(rst, r);
    e.gnt   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.sel   = 2'(m_sel);
    e.valid = (m_owner >= 0);
    e.dout  = mux_in[m_sel];
    sb_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs one step after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_cnt++;
        if (gnt === e.gnt && sel === e.sel && sel_valid === e.valid) begin
          pass_cnt++;
        end else begin
          $display("FAIL outputs t=%0t: gnt=%b sel=%b valid=%b, expected gnt=%b sel=%b valid=%b",
                   $time, gnt, sel, sel_valid, e.gnt, e.sel, e.valid);
        end
        if (e.valid) begin
          chk_cnt++;
          if (mux_out === e.dout) pass_cnt++;
          else $display("FAIL mux_out t=%0t: got %b, expected %b", $time, mux_out, e.dout);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst_n  = 1'b0;
    req    = 4'b0000;
    mux_in = 4'b1011;

    // Reset with all requests high
    cycle(1'b0, 4'b1111);
    cycle(1'b0, 4'b1111);

    // Single requester, then release
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);

    // Fairness with all requesting
    cycle(1'b0, 4'b0000);
    for (int i = 0; i < 9; i++) cycle(1'b1, 4'b1111);

    // Bubble-free handover on release
    cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b0011);
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b0010);

    // Lone requester saturates, then a newcomer takes over at once
    cycle(1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'b1000);
    cycle(1'b1, 4'b1010);
    cycle(1'b1, 4'b1010);

    // Reset mid-grant; first grant afterwards goes to in1
    cycle(1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1010);
    cycle(1'b0, 4'b1010);
    cycle(1'b1, 4'b1010);
    cycle(1'b1, 4'b1010);

    // Random traffic: requests mostly held, occasional toggles and resets
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      cycle(($urandom_range(0, 79) != 0), r);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
